// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the 5-stage core. Produces
//                the per-register stall/zero controls and PC write-enable
//                for load-use hazards, taken branches resolved in EX and
//                multi-cycle data-memory waits. Keeps a memory-wait FSM,
//                saturating stall/flush event counters and a sticky
//                memory-timeout flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   rising-edge clock
//    reset          in   asynchronous active-low reset
//    id_rs, id_rt   in   source register fields of the instruction in ID
//    id_uses_rt     in   ID instruction reads rt
//    ex_rt          in   destination register of the instruction in EX
//    ex_mem_read    in   EX instruction is a load
//    branch_taken   in   EX resolved a taken branch/jump
//    mem_busy       in   MEM-stage access not complete this cycle
//    pc_write       out  PC may load its next value
//    *_stall/*_zero out  pipeline-register hold / bubble-insert controls
//    state          out  0 = RUN, 1 = MEMWAIT (registered)
//    mem_timeout    out  sticky: a memory wait reached MAX_WAIT cycles
//    stall_cnt      out  saturating count of cycles with pc_write = 0
//    flush_cnt      out  saturating count of branch-flush cycles
// ============================================================================
module hazard_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_uses_rt,
    input  logic [REG_BITS-1:0] ex_rt,
    input  logic                ex_mem_read,
    input  logic                branch_taken,
    input  logic                mem_busy,
    output logic                pc_write,
    output logic                if_id_stall,
    output logic                if_id_zero,
    output logic                id_ex_stall,
    output logic                id_ex_zero,
    output logic                ex_mem_stall,
    output logic                ex_mem_zero,
    output logic                mem_wb_zero,
    output logic                state,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    // Wait counter must be able to hold MAX_WAIT itself.
    localparam int              c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_WAIT_W-1:0]   r_wait;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic                  w_load_use;
    logic                  w_flush;
    logic [c_WAIT_W-1:0]   w_wait_nxt;

    // A load writing r0 never creates a real dependency.
    assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Branch flush only wins once the memory freeze has released.
    assign w_flush = reset && !mem_busy && branch_taken;

    // ------------------------------------------------------------------
    // Control outputs: purely combinational, zero-cycle latency.
    // Priority: freeze > branch flush > load-use. Holding reset forces
    // every control low, including pc_write.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_zero   = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_zero   = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_zero  = 1'b0;
        mem_wb_zero  = 1'b0;
        if (reset) begin
            pc_write = 1'b1;
            if (mem_busy) begin
                // Hold everything upstream of MEM; MEM_WB gets a bubble so
                // the stalled access is not written back repeatedly.
                pc_write     = 1'b0;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_zero  = 1'b1;
            end else if (branch_taken) begin
                // Discard the two younger instructions in IF_ID and ID_EX;
                // any load-use on the discarded ID instruction is moot.
                if_id_zero = 1'b1;
                id_ex_zero = 1'b1;
            end else if (w_load_use) begin
                pc_write    = 1'b0;
                if_id_stall = 1'b1;
                id_ex_zero  = 1'b1;
            end
        end
    end

    // Next wait-counter value: starts at 1 on entry to MEMWAIT, then
    // increments while busy and saturates at MAX_WAIT.
    always_comb begin
        w_wait_nxt = '0;
        if (mem_busy) begin
            if (r_state == RUN) begin
                w_wait_nxt = c_WAIT_ONE;
            end else if (r_wait == c_WAIT_MAX) begin
                w_wait_nxt = r_wait;
            end else begin
                w_wait_nxt = r_wait + c_WAIT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM, timeout flag and event counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_wait      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_busy) begin
                        r_state <= MEMWAIT;
                    end
                end
                MEMWAIT: begin
                    if (!mem_busy) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
            r_wait <= w_wait_nxt;

            // Sticky until reset.
            if (mem_busy && (w_wait_nxt == c_WAIT_MAX)) begin
                r_timeout <= 1'b1;
            end

            if (!pc_write && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign state       = r_state;
    assign mem_timeout = r_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire
